// File: rtl/ysyx_22041412_ifu_pkg.sv
// Shared widths, reset PC, NOP encoding and the buffered fetch entry type for the IFU.
package ysyx_22041412_ifu_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;

  localparam logic [XLEN-1:0]   IFU_RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [INST_W-1:0] INST_NOP     = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
    return {pc[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ysyx_22041412_ifu_fifo.sv
// Parameterised synchronous FIFO with flush, used for request PCs and buffered instructions.
// DEPTH must be a power of two (>= 2) so the pointers wrap naturally.
module ysyx_22041412_ifu_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rdPtr_q;
  logic [PTR_W-1:0] wrPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush;
  logic             doPop;

  // A pop frees the head this cycle, so a full FIFO may still take a push alongside it.
  assign doPop  = pop_i && (count_q != '0);
  assign doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rdPtr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ysyx_22041412_ifu.sv
// Instruction fetch unit: issues word fetches, buffers {pc, inst} for decode, handles redirects.
// Optional IFU_PERF_CNT_EN builds the delivered-instruction and decode-stall counters.
module ysyx_22041412_ifu
  import ysyx_22041412_ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = IFU_RESET_PC,
  parameter int              FIFO_DEPTH = 2,
  parameter int              CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [INST_W-1:0] mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [XLEN-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [XLEN-1:0]   inst_pc,
  output logic [63:0]       perf_fetch_cnt,
  output logic [63:0]       perf_stall_cnt
);

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [CNT_W-1:0] dropCnt_q, dropCnt_d;
  logic [CNT_W-1:0] instCount, pcCount;
  logic [CNT_W:0]   reserved;
  logic [XLEN-1:0]  rspPc;
  fetch_entry_t     pushEntry, headEntry;
  logic             reqFire, rspLive, rspKeep, instPop;

  // Slots are reserved for every in-flight request, including ones that will be dropped.
  assign reserved      = {1'b0, instCount} + {1'b0, outstanding_q};
  assign mem_req_valid = rst_n && !redirect_valid && (reserved < (CNT_W+1)'(FIFO_DEPTH));
  assign mem_req_addr  = pc_q;
  assign reqFire       = mem_req_valid && mem_req_ready;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign rspLive = mem_rsp_valid && (outstanding_q != '0);
  assign rspKeep = rspLive && (dropCnt_q == '0) && (pcCount != '0) && !redirect_valid;

  assign inst_valid = (instCount != '0) && !redirect_valid;
  assign instPop    = inst_valid && inst_ready;
  assign pushEntry  = '{pc: rspPc, inst: mem_rsp_data};
  assign inst       = (instCount != '0) ? headEntry.inst : INST_NOP;
  assign inst_pc    = headEntry.pc;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    dropCnt_d     = dropCnt_q;
    if (redirect_valid) begin
      pc_d          = alignPc(redirect_pc);
      outstanding_d = outstanding_q - CNT_W'(rspLive);
      dropCnt_d     = outstanding_q - CNT_W'(rspLive);
    end else begin
      if (reqFire) pc_d = pc_q + 64'd4;
      outstanding_d = outstanding_q + CNT_W'(reqFire) - CNT_W'(rspLive);
      if (rspLive && (dropCnt_q != '0)) dropCnt_d = dropCnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
    end
  end

  // A redirect flushes the PC queue too; the dropped responses it held are tracked by dropCnt.
  ysyx_22041412_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (XLEN),
    .CNT_W (CNT_W)
  ) u_pcFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (reqFire),
    .pop_i   (rspKeep),
    .flush_i (redirect_valid),
    .wdata_i (pc_q),
    .rdata_o (rspPc),
    .count_o (pcCount)
  );

  ysyx_22041412_ifu_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_entry_t)),
    .CNT_W (CNT_W)
  ) u_instFifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rspKeep),
    .pop_i   (instPop),
    .flush_i (redirect_valid),
    .wdata_i (pushEntry),
    .rdata_o (headEntry),
    .count_o (instCount)
  );

`ifdef IFU_PERF_CNT_EN
  logic [63:0] fetchCnt_q;
  logic [63:0] stallCnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCnt_q <= '0;
      stallCnt_q <= '0;
    end else begin
      if (instPop) fetchCnt_q <= fetchCnt_q + 64'd1;
      if (inst_ready && !inst_valid && !redirect_valid) stallCnt_q <= stallCnt_q + 64'd1;
    end
  end

  assign perf_fetch_cnt = fetchCnt_q;
  assign perf_stall_cnt = stallCnt_q;
`else
  assign perf_fetch_cnt = 64'd0;
  assign perf_stall_cnt = 64'd0;
`endif

endmodule

// File: tb/tb_ysyx_22041412_ifu.sv
// Table-driven bench for ysyx_22041412_ifu; the memory side is driven cycle by cycle from the table.
// With IFU_PERF_CNT_EN defined the perf counters are expected to count, otherwise to read zero.
module tb_ysyx_22041412_ifu;

  localparam logic [63:0] B = 64'h0000_0000_8000_0000;
`ifdef IFU_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req_valid, mem_req_ready;
  logic [63:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst;
  logic [63:0] inst_pc, perf_fetch_cnt, perf_stall_cnt;

  always #5 clk = ~clk;

  ysyx_22041412_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  typedef struct {
    logic        rst;
    logic        reqReady;
    logic        rspValid;
    logic [31:0] rspData;
    logic        redir;
    logic [63:0] redirPc;
    logic        instReady;
    logic        expReqValid;
    logic [63:0] expAddr;
    logic        expInstValid;
    logic [63:0] expInstPc;
    logic [31:0] expInst;
  } vec_t;

  vec_t        vecs[$];
  int          totalCnt = 0;
  int          passCnt = 0;
  logic [63:0] expFetch = '0;
  logic [63:0] expStall = '0;

  function automatic vec_t mk(input logic rst, input logic rr, input logic rv, input logic [31:0] rd,
                              input logic re, input logic [63:0] rp, input logic ir,
                              input logic eqv, input logic [63:0] ea, input logic eiv,
                              input logic [63:0] epc, input logic [31:0] ei);
    vec_t v;
    v.rst = rst; v.reqReady = rr; v.rspValid = rv; v.rspData = rd;
    v.redir = re; v.redirPc = rp; v.instReady = ir;
    v.expReqValid = eqv; v.expAddr = ea; v.expInstValid = eiv;
    v.expInstPc = epc; v.expInst = ei;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reset lands mid-cycle with a response on the bus, which must be ignored.
  task automatic applyReset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_data = 32'hBAD0_0000;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;
    #1;
    checkOutput("reset mem_req_valid", mem_req_valid, 1'b0);
    checkOutput("reset inst_valid", inst_valid, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    checkOutput("reset held inst_valid", inst_valid, 1'b0);
    checkOutput("reset held perf_fetch_cnt", perf_fetch_cnt, 64'd0);
    checkOutput("reset held perf_stall_cnt", perf_stall_cnt, 64'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    mem_rsp_valid = 1'b0;
    expFetch = '0;
    expStall = '0;
  endtask

  task automatic applyStimulus(input int idx, input vec_t v);
    @(negedge clk);
    mem_req_ready  = v.reqReady;
    mem_rsp_valid  = v.rspValid;
    mem_rsp_data   = v.rspData;
    redirect_valid = v.redir;
    redirect_pc    = v.redirPc;
    inst_ready     = v.instReady;
    #1;
    checkOutput($sformatf("v%0d mem_req_valid", idx), mem_req_valid, v.expReqValid);
    checkOutput($sformatf("v%0d mem_req_addr", idx), mem_req_addr, v.expAddr);
    checkOutput($sformatf("v%0d inst_valid", idx), inst_valid, v.expInstValid);
    if (v.expInstValid) begin
      checkOutput($sformatf("v%0d inst_pc", idx), inst_pc, v.expInstPc);
      checkOutput($sformatf("v%0d inst", idx), inst, v.expInst);
    end
    checkOutput($sformatf("v%0d perf_fetch_cnt", idx), perf_fetch_cnt, PerfEn ? expFetch : 64'd0);
    checkOutput($sformatf("v%0d perf_stall_cnt", idx), perf_stall_cnt, PerfEn ? expStall : 64'd0);
    if (v.expInstValid && v.instReady) expFetch++;
    if (v.instReady && !v.expInstValid && !v.redir) expStall++;
  endtask

  initial begin
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b0;

    // Streaming with 1-cycle responses and decode always ready
    vecs.push_back(mk(1, 1,0,32'h0,          0,64'h0,1, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hA000_0000, 0,64'h0,1, 1,B+4,    0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hA000_0004, 0,64'h0,1, 0,B+8,    1,B,      32'hA000_0000));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,1, 1,B+8,    1,B+4,    32'hA000_0004));
    vecs.push_back(mk(0, 1,1,32'hA000_0008, 0,64'h0,1, 1,B+12,   0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hA000_000C, 0,64'h0,1, 0,B+16,   1,B+8,    32'hA000_0008));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,1, 1,B+16,   1,B+12,   32'hA000_000C));
    // Decode stalled: two requests fill the buffer, one pop frees one request slot
    vecs.push_back(mk(1, 1,0,32'h0,          0,64'h0,0, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hB000_0000, 0,64'h0,0, 1,B+4,    0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hB000_0004, 0,64'h0,0, 0,B+8,    1,B,      32'hB000_0000));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 0,B+8,    1,B,      32'hB000_0000));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 0,B+8,    1,B,      32'hB000_0000));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,1, 0,B+8,    1,B,      32'hB000_0000));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,B+8,    1,B+4,    32'hB000_0004));
    vecs.push_back(mk(0, 1,1,32'hB000_0008, 0,64'h0,0, 0,B+12,   1,B+4,    32'hB000_0004));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 0,B+12,   1,B+4,    32'hB000_0004));
    // Redirect with two outstanding (unaligned target), then redirect racing a response
    vecs.push_back(mk(1, 1,0,32'h0,          0,64'h0,1, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,1, 1,B+4,    0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          1,B+64'h103,1, 0,B+8, 0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0000, 0,64'h0,1, 0,B+64'h100, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0004, 0,64'h0,1, 1,B+64'h100, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,1, 1,B+64'h104, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0100, 0,64'h0,1, 0,B+64'h108, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0104, 0,64'h0,1, 0,B+64'h108, 1,B+64'h100, 32'hC000_0100));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,B+64'h108, 1,B+64'h104, 32'hC000_0104));
    vecs.push_back(mk(0, 1,1,32'hC000_0108, 1,B+64'h200,1, 0,B+64'h10C, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,B+64'h200, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0200, 0,64'h0,0, 1,B+64'h204, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,64'h0,0, 0,B+64'h208, 1,B+64'h200, 32'hC000_0200));
    // Redirect near the top of the address space: PC wraps to zero
    vecs.push_back(mk(0, 1,0,32'h0,          1,64'hFFFF_FFFF_FFFF_FFFE,0, 0,B+64'h208, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,1,32'hC000_0204, 0,64'h0,0, 1,64'hFFFF_FFFF_FFFF_FFFC, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 0,1,32'hCFFF_FFFC, 0,64'h0,0, 1,64'h0, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,64'h0,1, 1,64'h0, 1,64'hFFFF_FFFF_FFFF_FFFC, 32'hCFFF_FFFC));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,64'h0, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,64'h4, 0,64'h0, 32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 0,64'h8, 0,64'h0, 32'h0));
    // Reset with two outstanding; late responses afterwards must not be delivered
    vecs.push_back(mk(1, 0,1,32'hDEAD_0000, 0,64'h0,0, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 0,1,32'hDEAD_0004, 0,64'h0,0, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 1,0,32'h0,          0,64'h0,0, 1,B,      0,64'h0,  32'h0));
    vecs.push_back(mk(0, 0,1,32'hD000_0000, 0,64'h0,0, 1,B+4,    0,64'h0,  32'h0));
    vecs.push_back(mk(0, 0,0,32'h0,          0,64'h0,1, 1,B+4,    1,B,      32'hD000_0000));
    vecs.push_back(mk(0, 0,0,32'h0,          0,64'h0,0, 1,B+4,    0,64'h0,  32'h0));

    foreach (vecs[i]) begin
      if (vecs[i].rst) applyReset();
      applyStimulus(i, vecs[i]);
    end

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
